frame_cfg_sequencer: RTL and testbench

FRAME_CFG_SEQUENCER -- requirements
Module: frame_cfg_sequencer

---
 rtl/frame_cfg_sequencer_pkg.sv | 17 +
 rtl/frame_cfg_sequencer_drain_timer.sv | 34 +++
 rtl/frame_cfg_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_frame_cfg_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_sequencer_pkg.sv
// Shared types and defaults for the frame configuration sequencer.
//   state_e    : sequencer states
//   THRESH_W   : default threshold width
//   THRESH_RST : default threshold reset value
package frame_cfg_sequencer_pkg;

    localparam int unsigned THRESH_W   = 26;
    localparam int unsigned THRESH_RST = 4000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_WAIT_SOF = 2'd2,
        ST_APPLY    = 2'd3
    } state_e;

endpackage

// File: rtl/frame_cfg_sequencer_drain_timer.sv
// Drain timeout counter: cleared on FLUSH entry, counts while enabled.
//   i_sysclk : clock
//   i_rstn   : synchronous active-low reset
//   i_clear  : zero the count (wins over i_enable)
//   i_enable : count once per cycle
//   o_tc_c   : combinational terminal count (count == DRAIN_TIMEOUT-1)
module frame_cfg_sequencer_drain_timer #(
    parameter int unsigned DRAIN_TIMEOUT = 2_000_000
) (
    input  logic i_sysclk,
    input  logic i_rstn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT);

    logic [CNT_W-1:0] r_count;

    // Counter register
    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == CNT_W'(DRAIN_TIMEOUT - 1));

endmodule

// File: rtl/frame_cfg_sequencer.sv
// Frame-synchronous configuration sequencer. Captures config requests,
// flushes the pipeline when enables change, and applies the pending
// config on the next start-of-frame.
//   i_sysclk, i_rstn          : clock, synchronous active-low reset
//   i_sof                     : start-of-frame pulse
//   i_cfg_valid               : request strobe for i_gaussian_en/i_sobel_en/i_threshold
//   i_drained                 : pipeline empty (level)
//   o_flush                   : pipeline flush request
//   o_cfg_busy                : state is not IDLE
//   o_gaussian_enable, o_sobel_enable, o_sobel_threshold : active config
//   o_apply                   : pulse when active config updates
//   o_timeout_err             : sticky drain timeout flag
module frame_cfg_sequencer
    import frame_cfg_sequencer_pkg::*;
#(
    parameter int unsigned THRESH_W      = frame_cfg_sequencer_pkg::THRESH_W,
    parameter int unsigned THRESH_RST    = frame_cfg_sequencer_pkg::THRESH_RST,
    parameter int unsigned DRAIN_TIMEOUT = 2_000_000
) (
    input  logic                i_sysclk,
    input  logic                i_rstn,
    input  logic                i_sof,
    input  logic                i_cfg_valid,
    input  logic                i_gaussian_en,
    input  logic                i_sobel_en,
    input  logic [THRESH_W-1:0] i_threshold,
    input  logic                i_drained,
    output logic                o_flush,
    output logic                o_cfg_busy,
    output logic                o_gaussian_enable,
    output logic                o_sobel_enable,
    output logic [THRESH_W-1:0] o_sobel_threshold,
    output logic                o_apply,
    output logic                o_timeout_err
);

    state_e              r_state;
    state_e              w_state_nxt;

    logic                r_pend_gauss;
    logic                r_pend_sobel;
    logic [THRESH_W-1:0] r_pend_thr;
    logic                r_req_held;

    logic                r_flush;
    logic                r_busy;
    logic                r_gauss;
    logic                r_sobel;
    logic [THRESH_W-1:0] r_thr;
    logic                r_apply;
    logic                r_timeout_err;

    logic                w_flush_nxt;
    logic                w_apply_nxt;
    logic                w_err_set;
    logic                w_held_nxt;
    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic                w_tmr_tc;
    logic                w_req;
    logic                w_req_gauss;
    logic                w_req_sobel;
    logic                w_en_diff;

    frame_cfg_sequencer_drain_timer #(
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_drain_timer (
        .i_sysclk (i_sysclk),
        .i_rstn   (i_rstn),
        .i_clear  (w_tmr_clr),
        .i_enable (w_tmr_en),
        .o_tc_c   (w_tmr_tc)
    );

    // A fresh strobe takes priority over a request held from the APPLY cycle
    assign w_req       = i_cfg_valid | r_req_held;
    assign w_req_gauss = i_cfg_valid ? i_gaussian_en : r_pend_gauss;
    assign w_req_sobel = i_cfg_valid ? i_sobel_en    : r_pend_sobel;
    assign w_en_diff   = (w_req_gauss != r_gauss) || (w_req_sobel != r_sobel);

    assign w_tmr_en  = (r_state == ST_FLUSH);
    assign w_tmr_clr = (w_state_nxt == ST_FLUSH) && (r_state != ST_FLUSH);

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush;
        w_apply_nxt = 1'b0;
        w_err_set   = 1'b0;
        w_held_nxt  = r_req_held;

        case (r_state)
            ST_IDLE: begin
                w_held_nxt = 1'b0;
                if (w_req) begin
                    if (w_en_diff) begin
                        w_state_nxt = ST_FLUSH;
                        w_flush_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_SOF;
                        w_flush_nxt = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                w_flush_nxt = 1'b1;
                if (i_drained) begin
                    w_state_nxt = ST_WAIT_SOF;
                end else if (w_tmr_tc) begin
                    w_state_nxt = ST_WAIT_SOF;
                    w_err_set   = 1'b1;
                end
            end
            ST_WAIT_SOF: begin
                if (i_sof) begin
                    // Active takes the old pending; a coincident request is held
                    w_state_nxt = ST_APPLY;
                    w_apply_nxt = 1'b1;
                    w_flush_nxt = 1'b0;
                    if (i_cfg_valid) begin
                        w_held_nxt = 1'b1;
                    end
                end else if (i_cfg_valid && !r_flush && w_en_diff) begin
                    w_state_nxt = ST_FLUSH;
                    w_flush_nxt = 1'b1;
                end
            end
            ST_APPLY: begin
                w_state_nxt = ST_IDLE;
                w_flush_nxt = 1'b0;
                if (i_cfg_valid) begin
                    w_held_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    // State, pending, active and status registers
    always_ff @(posedge i_sysclk) begin
        if (!i_rstn) begin
            r_state       <= ST_IDLE;
            r_pend_gauss  <= 1'b0;
            r_pend_sobel  <= 1'b0;
            r_pend_thr    <= THRESH_W'(THRESH_RST);
            r_req_held    <= 1'b0;
            r_flush       <= 1'b0;
            r_busy        <= 1'b0;
            r_gauss       <= 1'b0;
            r_sobel       <= 1'b0;
            r_thr         <= THRESH_W'(THRESH_RST);
            r_apply       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_held    <= w_held_nxt;
            r_flush       <= w_flush_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_apply       <= w_apply_nxt;
            r_timeout_err <= r_timeout_err | w_err_set;
            if (i_cfg_valid) begin
                r_pend_gauss <= i_gaussian_en;
                r_pend_sobel <= i_sobel_en;
                r_pend_thr   <= i_threshold;
            end
            if (w_apply_nxt) begin
                r_gauss <= r_pend_gauss;
                r_sobel <= r_pend_sobel;
                r_thr   <= r_pend_thr;
            end
        end
    end

    assign o_flush           = r_flush;
    assign o_cfg_busy        = r_busy;
    assign o_gaussian_enable = r_gauss;
    assign o_sobel_enable    = r_sobel;
    assign o_sobel_threshold = r_thr;
    assign o_apply           = r_apply;
    assign o_timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_frame_cfg_sequencer.sv
// Directed self-checking bench for frame_cfg_sequencer (DRAIN_TIMEOUT = 16).
module tb_frame_cfg_sequencer;

    localparam int unsigned TW = 26;

    logic          clk;
    logic          rstn;
    logic          sof;
    logic          cfg_valid;
    logic          gauss_in;
    logic          sobel_in;
    logic [TW-1:0] thr_in;
    logic          drained;
    logic          flush;
    logic          busy;
    logic          gauss;
    logic          sobel;
    logic [TW-1:0] thr;
    logic          apply;
    logic          terr;

    int checks   = 0;
    int failures = 0;
    int flush_cnt = 0;
    int apply_cnt = 0;
    int base_f;
    int base_a;

    frame_cfg_sequencer #(
        .THRESH_W      (TW),
        .THRESH_RST    (4000),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .i_sysclk          (clk),
        .i_rstn            (rstn),
        .i_sof             (sof),
        .i_cfg_valid       (cfg_valid),
        .i_gaussian_en     (gauss_in),
        .i_sobel_en        (sobel_in),
        .i_threshold       (thr_in),
        .i_drained         (drained),
        .o_flush           (flush),
        .o_cfg_busy        (busy),
        .o_gaussian_enable (gauss),
        .o_sobel_enable    (sobel),
        .o_sobel_threshold (thr),
        .o_apply           (apply),
        .o_timeout_err     (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with flush / apply high
    always @(posedge clk) begin
        if (flush) flush_cnt <= flush_cnt + 1;
        if (apply) apply_cnt <= apply_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input logic g, input logic s, input int t);
        cfg_valid = 1'b1;
        gauss_in  = g;
        sobel_in  = s;
        thr_in    = TW'(t);
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_sof();
        sof = 1'b1;
        step(1);
        sof = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; sof = 1'b0; cfg_valid = 1'b0;
        gauss_in = 1'b0; sobel_in = 1'b0; thr_in = '0; drained = 1'b0;
        step(3);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_apply", 32'(apply), 0);
        chk("rst_err",   32'(terr),  0);
        chk("rst_gauss", 32'(gauss), 0);
        chk("rst_sobel", 32'(sobel), 0);
        chk("rst_thr",   32'(thr),   4000);
        rstn = 1'b1;
        step(1);

        // Enable change: flush, drain after 10, SOF 50 later
        base_f = flush_cnt;
        req(1'b1, 1'b0, 4000);
        chk("t1_flush_on", 32'(flush), 1);
        chk("t1_busy",     32'(busy),  1);
        step(9);
        drained = 1'b1;
        step(1);
        drained = 1'b0;
        chk("t1_flush_wait", 32'(flush), 1);
        step(49);
        pulse_sof();
        chk("t1_apply",    32'(apply), 1);
        chk("t1_gauss",    32'(gauss), 1);
        chk("t1_flush_off", 32'(flush), 0);
        chk("t1_flush_len", 32'(flush_cnt - base_f), 60);
        step(1);
        chk("t1_apply_off", 32'(apply), 0);
        chk("t1_idle",      32'(busy),  0);

        // Threshold-only; SOF in the request cycle is ignored
        base_f = flush_cnt;
        sof = 1'b1;
        req(1'b1, 1'b0, 4500);
        sof = 1'b0;
        chk("t2_busy",     32'(busy),  1);
        chk("t2_no_apply", 32'(apply), 0);
        chk("t2_thr_old",  32'(thr),   4000);
        step(3);
        pulse_sof();
        chk("t2_apply", 32'(apply), 1);
        chk("t2_thr",   32'(thr),   4500);
        step(1);
        chk("t2_no_flush", 32'(flush_cnt - base_f), 0);
        chk("t2_idle",     32'(busy), 0);

        // Newest of three requests wins, single apply
        base_a = apply_cnt;
        req(1'b1, 1'b0, 1000);
        req(1'b1, 1'b0, 2000);
        req(1'b1, 1'b0, 3000);
        chk("t3_flush", 32'(flush), 0);
        step(2);
        pulse_sof();
        chk("t3_thr", 32'(thr), 3000);
        step(2);
        chk("t3_one_apply", 32'(apply_cnt - base_a), 1);

        // Request in APPLY cycle is held and processed from IDLE
        req(1'b1, 1'b0, 3500);
        step(1);
        pulse_sof();
        chk("t4_apply", 32'(apply), 1);
        chk("t4_thr",   32'(thr),   3500);
        req(1'b1, 1'b1, 3500);
        chk("t4_idle",      32'(busy),  0);
        chk("t4_sobel_old", 32'(sobel), 0);
        step(1);
        chk("t4_flush", 32'(flush), 1);
        drained = 1'b1;
        step(1);
        drained = 1'b0;
        step(2);
        pulse_sof();
        chk("t4_sobel", 32'(sobel), 1);
        chk("t4_apply2", 32'(apply), 1);
        step(1);

        // WAIT_SOF enable change moves to FLUSH, then drain times out
        req(1'b1, 1'b1, 100);
        chk("t5_noflush", 32'(flush), 0);
        req(1'b0, 1'b1, 200);
        chk("t5_flush", 32'(flush), 1);
        step(15);
        chk("t5_err_pre", 32'(terr), 0);
        step(1);
        chk("t5_err",        32'(terr),  1);
        chk("t5_flush_wait", 32'(flush), 1);
        chk("t5_busy",       32'(busy),  1);
        step(2);
        pulse_sof();
        chk("t5_apply", 32'(apply), 1);
        chk("t5_gauss", 32'(gauss), 0);
        chk("t5_thr",   32'(thr),   200);
        chk("t5_flush_off", 32'(flush), 0);
        step(3);
        chk("t5_err_sticky", 32'(terr), 1);

        // Reset mid-FLUSH discards the request
        base_a = apply_cnt;
        req(1'b1, 1'b1, 300);
        step(2);
        chk("t6_flush", 32'(flush), 1);
        rstn = 1'b0;
        step(1);
        chk("t6_flush_off", 32'(flush), 0);
        chk("t6_err",       32'(terr),  0);
        chk("t6_gauss",     32'(gauss), 0);
        chk("t6_sobel",     32'(sobel), 0);
        chk("t6_thr",       32'(thr),   4000);
        rstn = 1'b1;
        step(2);
        pulse_sof();
        step(2);
        chk("t6_no_apply", 32'(apply_cnt - base_a), 0);
        chk("t6_thr_keep", 32'(thr), 4000);

        // Drained coincides with terminal count: no error
        req(1'b1, 1'b0, 4000);
        step(15);
        drained = 1'b1;
        step(1);
        drained = 1'b0;
        chk("t7_err",   32'(terr),  0);
        chk("t7_flush", 32'(flush), 1);
        pulse_sof();
        chk("t7_gauss", 32'(gauss), 1);
        step(1);

        // Identical request still applies without flush
        base_f = flush_cnt;
        req(1'b1, 1'b0, 4000);
        chk("t8_busy", 32'(busy), 1);
        step(1);
        pulse_sof();
        chk("t8_apply", 32'(apply), 1);
        chk("t8_no_flush", 32'(flush_cnt - base_f), 0);
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
